coef_ram_sched: RTL and testbench

COEF_RAM_SCHED -- requirements
Module: coef_ram_sched

---
 rtl/coef_ram_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_coef_ram_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module   : coef_ram_sched
//  Purpose  : Arbitrates a single-port coefficient RAM between host writes
//             and atomic FIR coefficient sweeps.
//
//             A sweep reads addresses 0..TAP_NUM-1 back to back. Each
//             coefficient is presented on the FIR side one cycle after its
//             read, which matches the RAM's registered read data. Host writes
//             take one cycle. Out-of-range host addresses are acknowledged
//             with an error and never reach the RAM.
//
//             A start that arrives while the block is busy is held in a
//             one-deep pending flag. A start that arrives while the flag is
//             already set is dropped and counted as an overrun.
//
//  Ports    : iClk12M, iRst           clock / sync active-high reset
//             iHostReq/Addr/WtDt      host write request (held until ack)
//             oHostAck, oHostErr      grant pulse, out-of-range qualifier
//             iFirStart               sweep request pulse
//             oFirCoefValid/Coef/Idx  coefficient stream
//             oFirDone                pulse with the last coefficient
//             oBusy, oOverrunCnt      status
//             oCsnRam, oWrnRam, oAddrRam, oWtDtRam, iRdDtRam   RAM port
//
//  Config   : COEF_OVERRUN_CNT_EN - when defined, oOverrunCnt counts dropped
//             starts and saturates at 255. When undefined, it is tied to 0.
//
//  Revision : 1.0  initial release
// ============================================================================
module coef_ram_sched #(
   parameter int TAP_NUM = 11,
   parameter int AW      = 4,
   parameter int DW      = 16
) (
   input  logic          iClk12M,
   input  logic          iRst,
   input  logic          iHostReq,
   input  logic [AW-1:0] iHostAddr,
   input  logic [DW-1:0] iHostWtDt,
   output logic          oHostAck,
   output logic          oHostErr,
   input  logic          iFirStart,
   output logic          oFirCoefValid,
   output logic [DW-1:0] oFirCoef,
   output logic [AW-1:0] oFirCoefIdx,
   output logic          oFirDone,
   output logic          oBusy,
   output logic [7:0]    oOverrunCnt,
   output logic          oCsnRam,
   output logic          oWrnRam,
   output logic [AW-1:0] oAddrRam,
   output logic [DW-1:0] oWtDtRam,
   input  logic [DW-1:0] iRdDtRam
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WRITE = 2'd1;
   localparam logic [1:0] c_SWEEP = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   localparam logic [AW-1:0] c_LAST_TAP = AW'(TAP_NUM - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_nextState;
   logic [AW-1:0] r_tapCnt;
   logic          r_pend;       // one-deep pending start
   logic          r_hostPri;    // host wins the next IDLE arbitration
   logic          r_hostSeen;   // host was waiting during the current sweep
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wtDt;
   logic          r_coefValid;
   logic [AW-1:0] r_coefIdx;

   logic          w_startReq;
   logic          w_goSweep;
   logic          w_goWrite;
   logic          w_setPend;
   logic          w_addrOk;

   assign w_startReq = iFirStart | r_pend;
   assign w_addrOk   = (32'(r_addr) < TAP_NUM);

   // ------------------------------------------------------------------------
   // Next-state and IDLE arbitration.
   // A host that waited through a sweep gets the RAM before the next sweep.
   // Otherwise a start request beats a simultaneous host request.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      w_goSweep   = 1'b0;
      w_goWrite   = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (r_hostPri && iHostReq) begin
               w_goWrite   = 1'b1;
               w_nextState = c_WRITE;
            end else if (w_startReq) begin
               w_goSweep   = 1'b1;
               w_nextState = c_SWEEP;
            end else if (iHostReq) begin
               w_goWrite   = 1'b1;
               w_nextState = c_WRITE;
            end
         end
         c_WRITE: w_nextState = c_IDLE;
         c_SWEEP: begin
            if (r_tapCnt == c_LAST_TAP) begin
               w_nextState = c_DRAIN;
            end
         end
         c_DRAIN: w_nextState = c_IDLE;
         default: w_nextState = c_IDLE;
      endcase
   end

   // A start that does not launch a sweep directly must wait in the flag.
   // This also covers IDLE cycles in which the host has priority.
   assign w_setPend = iFirStart & ~w_goSweep;

   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_state     <= c_IDLE;
         r_tapCnt    <= '0;
         r_pend      <= 1'b0;
         r_hostPri   <= 1'b0;
         r_hostSeen  <= 1'b0;
         r_addr      <= '0;
         r_wtDt      <= '0;
         r_coefValid <= 1'b0;
         r_coefIdx   <= '0;
      end else begin
         r_state <= w_nextState;

         // pending start flag
         if (w_goSweep) begin
            r_pend <= 1'b0;
         end else if (w_setPend) begin
            r_pend <= 1'b1;
         end

         // tap counter
         if (w_goSweep) begin
            r_tapCnt <= '0;
         end else if (r_state == c_SWEEP) begin
            r_tapCnt <= r_tapCnt + AW'(1);
         end else if (r_state == c_DRAIN) begin
            r_tapCnt <= '0;
         end

         // host capture
         if (w_goWrite) begin
            r_addr <= iHostAddr;
            r_wtDt <= iHostWtDt;
         end

         // Track whether the host was waiting at any point of the sweep,
         // including the IDLE cycle that launched it.
         if (w_goSweep) begin
            r_hostSeen <= iHostReq;
         end else if ((r_state == c_SWEEP) && iHostReq) begin
            r_hostSeen <= 1'b1;
         end else if (r_state == c_DRAIN) begin
            r_hostSeen <= 1'b0;
         end

         // A flag left over from a host that has since withdrawn must not
         // stall later sweeps.
         if (r_state == c_DRAIN) begin
            r_hostPri <= r_hostSeen | iHostReq;
         end else if ((r_state == c_IDLE) && (w_goWrite || !iHostReq)) begin
            r_hostPri <= 1'b0;
         end

         // Coefficient qualifier trails the read by one cycle. The index
         // register therefore still holds the last tap during DRAIN.
         r_coefValid <= (r_state == c_SWEEP);
         r_coefIdx   <= (r_state == c_SWEEP) ? r_tapCnt : '0;
      end
   end

   // ------------------------------------------------------------------------
   // Overrun counter
   // ------------------------------------------------------------------------
`ifdef COEF_OVERRUN_CNT_EN
   logic [7:0] r_overrunCnt;
   logic       w_drop;

   assign w_drop = w_setPend & r_pend;

   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_overrunCnt <= 8'h00;
      end else if (w_drop && (r_overrunCnt != 8'hFF)) begin
         r_overrunCnt <= r_overrunCnt + 8'h01;
      end
   end

   assign oOverrunCnt = r_overrunCnt;
`else
   assign oOverrunCnt = 8'h00;
`endif

   // ------------------------------------------------------------------------
   // RAM port: decoded from the state registers only.
   // The RAM is idle in IDLE and DRAIN, and during an out-of-range write.
   // ------------------------------------------------------------------------
   always_comb begin
      oCsnRam  = 1'b1;
      oWrnRam  = 1'b1;
      oAddrRam = '0;
      oWtDtRam = '0;
      case (r_state)
         c_WRITE: begin
            if (w_addrOk) begin
               oCsnRam  = 1'b0;
               oWrnRam  = 1'b0;
               oAddrRam = r_addr;
               oWtDtRam = r_wtDt;
            end
         end
         c_SWEEP: begin
            oCsnRam  = 1'b0;
            oAddrRam = r_tapCnt;
         end
         default: begin
            oCsnRam  = 1'b1;
         end
      endcase
   end

   assign oHostAck      = (r_state == c_WRITE);
   assign oHostErr      = (r_state == c_WRITE) & ~w_addrOk;
   assign oBusy         = (r_state != c_IDLE);
   assign oFirCoefValid = r_coefValid;
   // The RAM data is already registered. Gate it so the bus rests at zero.
   assign oFirCoef      = r_coefValid ? iRdDtRam : '0;
   assign oFirCoefIdx   = r_coefIdx;
   assign oFirDone      = (r_state == c_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_coef_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coef_ram_sched
//  Purpose  : Scoreboard bench for coef_ram_sched with a registered RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coef_ram_sched;

   logic        clk = 1'b0;
   logic        iRst;
   logic        iHostReq;
   logic [3:0]  iHostAddr;
   logic [15:0] iHostWtDt;
   logic        oHostAck, oHostErr;
   logic        iFirStart;
   logic        oFirCoefValid;
   logic [15:0] oFirCoef;
   logic [3:0]  oFirCoefIdx;
   logic        oFirDone, oBusy;
   logic [7:0]  oOverrunCnt;
   logic        oCsnRam, oWrnRam;
   logic [3:0]  oAddrRam;
   logic [15:0] oWtDtRam;
   logic [15:0] iRdDtRam;

   always #5 clk = ~clk;

   coef_ram_sched #(.TAP_NUM(11), .AW(4), .DW(16)) dut (
      .iClk12M(clk), .iRst(iRst),
      .iHostReq(iHostReq), .iHostAddr(iHostAddr), .iHostWtDt(iHostWtDt),
      .oHostAck(oHostAck), .oHostErr(oHostErr),
      .iFirStart(iFirStart),
      .oFirCoefValid(oFirCoefValid), .oFirCoef(oFirCoef), .oFirCoefIdx(oFirCoefIdx),
      .oFirDone(oFirDone), .oBusy(oBusy), .oOverrunCnt(oOverrunCnt),
      .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam),
      .oWtDtRam(oWtDtRam), .iRdDtRam(iRdDtRam)
   );

   // registered-read RAM model
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (!oCsnRam) begin
         if (!oWrnRam) mem[oAddrRam] <= oWtDtRam;
         else          iRdDtRam      <= mem[oAddrRam];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] coef;
      logic        done;
      int          cyc;
   } coef_t;

   typedef struct {
      logic err;
      int   cyc;
   } host_t;

   coef_t cq[$];
   host_t hq[$];
   logic [15:0] em [11];   // expected RAM contents as seen by the bench
   int nvec  = 0;
   int nfail = 0;
   int expOvr;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      coef_t e;
      host_t h;
      if (oFirCoefValid) begin
         if (cq.size() == 0) begin
            check("unexpected_coef_valid", 64'(oFirCoefIdx), 64'hFFFF);
         end else begin
            e = cq.pop_front();
            check("coef_idx",  64'(oFirCoefIdx), 64'(e.idx));
            check("coef_data", 64'(oFirCoef),    64'(e.coef));
            check("fir_done",  64'(oFirDone),    64'(e.done));
            if (e.cyc >= 0) check("coef_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (oFirDone) check("done_has_valid", 64'(oFirCoefValid), 64'd1);
      if (oHostAck) begin
         if (hq.size() == 0) begin
            check("unexpected_host_ack", 64'(oHostAck), 64'd0);
         end else begin
            h = hq.pop_front();
            check("host_err", 64'(oHostErr), 64'(h.err));
            check("host_ram_cs", 64'({oCsnRam, oWrnRam}), h.err ? 64'd3 : 64'd0);
            if (h.cyc >= 0) check("host_ack_cycle", 64'(cyc), 64'(h.cyc));
         end
      end
   end

   function automatic logic [63:0] outs();
      return 64'({oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oHostAck, oHostErr,
                  oFirCoefValid, oFirCoef, oFirCoefIdx, oFirDone, oBusy});
   endfunction
   // csn=1, wrn=1, everything else 0
   localparam logic [63:0] c_RST_OUTS = 64'(47'b11) << 45;

   task automatic push_sweep(input int s);
      for (int k = 0; k < 11; k++)
         cq.push_back('{idx: 4'(k), coef: em[k], done: (k == 10), cyc: s + 2 + k});
   endtask

   task automatic pulse_start(output int s);
      @(posedge clk); #1;
      iFirStart = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      iFirStart = 1'b0;
   endtask

   task automatic start_at(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
      iFirStart = 1'b1;
      @(posedge clk); #1;
      iFirStart = 1'b0;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d,
                             input logic err, input int ackOff);
      bit got = 0;
      @(posedge clk); #1;
      hq.push_back('{err: err, cyc: cyc + ackOff});
      iHostReq = 1'b1; iHostAddr = a; iHostWtDt = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (oHostAck) begin got = 1; break; end
      end
      if (!got) check("host_ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      iHostReq = 1'b0;
      if (!err && a < 11) em[a] = d;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (cq.size() == 0 && hq.size() == 0) break;
         @(posedge clk);
      end
      check("drain", 64'(cq.size() + hq.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
      iRst = 1'b1; iHostReq = 1'b0; iHostAddr = '0; iHostWtDt = '0; iFirStart = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs(), c_RST_OUTS);
      check("reset_overrun", 64'(oOverrunCnt), 64'd0);
      @(posedge clk); #1;
      iRst = 1'b0;

      // fill the table, then one sweep with exact latency
      for (int a = 0; a < 11; a++) host_write(4'(a), 16'h0100 + 16'(a), 1'b0, 1);
      pulse_start(s);
      push_sweep(s);
      wait_drain(100);
      check("idle_after_sweep", outs(), c_RST_OUTS);

      // out-of-range writes leave the table alone
      host_write(4'hB, 16'hBEEF, 1'b1, 1);
      host_write(4'hF, 16'h1234, 1'b1, 1);
      pulse_start(s);
      push_sweep(s);
      wait_drain(100);

      // host and start together: sweep, host write, then pending sweep
      fork
         host_write(4'h3, 16'h0A03, 1'b0, 14);
         begin
            pulse_start(s);
            push_sweep(s);
            em[3] = 16'h0A03;
            start_at(s + 2);
            push_sweep(s + 15);
         end
      join
      wait_drain(100);

      // three starts during a sweep: one pends, two are dropped
      pulse_start(s);
      push_sweep(s);
      push_sweep(s + 13);
      start_at(s + 3);
      start_at(s + 5);
      start_at(s + 7);
      wait_drain(100);
`ifdef COEF_OVERRUN_CNT_EN
      expOvr = 2;
`else
      expOvr = 0;
`endif
      check("overrun_cnt", 64'(oOverrunCnt), 64'(expOvr));

      // reset at sweep cycle 6
      pulse_start(s);
      for (int k = 0; k < 5; k++)
         cq.push_back('{idx: 4'(k), coef: em[k], done: 1'b0, cyc: s + 2 + k});
      while (cyc < s + 6) begin @(posedge clk); #1; end
      iRst = 1'b1;
      @(posedge clk); #1;
      iRst = 1'b0;
      @(negedge clk);
      check("abort_outputs", outs(), c_RST_OUTS);
      check("abort_overrun", 64'(oOverrunCnt), 64'd0);
      wait_drain(20);

      // table survives the aborted sweep
      pulse_start(s);
      push_sweep(s);
      wait_drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
`default_nettype wire
